turfio_cin_autoalign: RTL and testbench

- Parametrised multi-channel successor to the single-channel CIN receive path.
- Owns the shared IDELAY load bus of NUM_CH CIN receivers.
- On request, for each enabled channel in turn: sweeps the IDELAY tap, checks the 4-bit ISERDES nibble stream against a fixed 32-bit training pattern, finds the widest passing eye, and loads its centre tap.
- Runs in the rxclk domain. Reports per-channel lock status, centre tap and bit offset to the control logic.

---
 rtl/turfio_cin_autoalign.sv | 157 +++++++++++++++
 tb/tb_turfio_cin_autoalign.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turfio_cin_autoalign.sv
// turfio_cin_autoalign: sweeps IDELAY taps per CIN channel, finds the widest training-pattern eye and loads its centre.
module turfio_cin_autoalign #(
  parameter int          NUM_CH        = 4,
  parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter int          TAP_STEP      = 8,
  parameter int          TAP_MAX       = 511,
  parameter int          SETTLE_CYCLES = 8,
  parameter int          DWELL_CYCLES  = 64,
  parameter int          MIN_EYE       = 3
) (
  input  logic                  rxclk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [NUM_CH-1:0]     ch_mask_i,
  input  logic [4*NUM_CH-1:0]   data_i,
  output logic [NUM_CH-1:0]     delay_load_o,
  output logic [1:0]            delay_sel_o,
  output logic [8:0]            delay_cntvaluein_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [NUM_CH-1:0]     ch_ok_o,
  output logic [9*NUM_CH-1:0]   ch_tap_o,
  output logic [2*NUM_CH-1:0]   ch_bitoff_o
);
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2((SETTLE_CYCLES > DWELL_CYCLES ? SETTLE_CYCLES : DWELL_CYCLES) + 1);
  localparam logic [63:0] PP = {TRAIN_PATTERN, TRAIN_PATTERN};
  typedef enum logic [2:0] {IDLE, SELECT, LOAD, SETTLE, DWELL, EVAL, CENTER, DONE} state_t;
  state_t state, state_n;
  logic [NUM_CH-1:0] pend;
  logic [CHW-1:0] ch, ch_n;
  logic [9:0] tap, tap_nx, cur_len, cur_start, best_len, best_start, fin_len, fin_start, centre;
  logic [1:0] cur_rot, best_rot, fin_rot, rot, dwell_rot;
  logic [CW-1:0] cnt;
  logic [31:0] sr [NUM_CH];
  logic [31:0] sel_sr;
  logic [63:0] rp;
  logic [19:0] span;
  logic match, dwell_ok, last, settle_end, dwell_end, extend, lock;
  assign delay_sel_o = 2'b00;
  always_comb begin
    sel_sr = sr[ch];
    match = 1'b0;
    rot = 2'd0;
    rp = '0;
    for (int r = 0; r < 32; r++) begin
      rp = PP >> r;
      if (sel_sr == rp[31:0]) begin
        match = 1'b1;
        rot = 2'(r);
      end
    end
    ch_n = '0;
    for (int n = NUM_CH - 1; n >= 0; n--) if (pend[n]) ch_n = CHW'(n);
    tap_nx = tap + 10'(TAP_STEP);
    last = tap_nx > 10'(TAP_MAX);
    settle_end = cnt == CW'(SETTLE_CYCLES - 1);
    dwell_end = cnt == CW'(DWELL_CYCLES - 1);
    extend = dwell_ok && (cur_len == 10'd0 || dwell_rot == cur_rot);
    // the eye still open at the end of the sweep competes with the best closed one
    fin_len = cur_len > best_len ? cur_len : best_len;
    fin_start = cur_len > best_len ? cur_start : best_start;
    fin_rot = cur_len > best_len ? cur_rot : best_rot;
    span = 20'(fin_len - 10'd1) * 20'(TAP_STEP);
    centre = fin_start + span[10:1];
    lock = fin_len >= 10'(MIN_EYE);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_i ? SELECT : IDLE;
      SELECT:  state_n = |pend ? LOAD : DONE;
      LOAD:    state_n = SETTLE;
      SETTLE:  state_n = settle_end ? DWELL : SETTLE;
      DWELL:   state_n = dwell_end ? EVAL : DWELL;
      EVAL:    state_n = last ? CENTER : LOAD;
      CENTER:  state_n = SELECT;
      default: state_n = IDLE;
    endcase
    busy_o = state != IDLE && state != DONE;
    done_o = state == DONE;
    delay_load_o = (state == LOAD || state == CENTER) ? NUM_CH'(1) << ch : '0;
    delay_cntvaluein_o = state == LOAD ? tap[8:0] : (state == CENTER && lock) ? centre[8:0] : 9'd0;
  end
  always_ff @(posedge rxclk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge rxclk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend <= '0;
      ch <= '0;
      tap <= '0;
      cnt <= '0;
      dwell_ok <= 1'b0;
      dwell_rot <= '0;
      cur_len <= '0;
      cur_start <= '0;
      cur_rot <= '0;
      best_len <= '0;
      best_start <= '0;
      best_rot <= '0;
      ch_ok_o <= '0;
      ch_tap_o <= '0;
      ch_bitoff_o <= '0;
      for (int n = 0; n < NUM_CH; n++) sr[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) sr[n] <= {data_i[4*n +: 4], sr[n][31:4]};
      case (state)
        IDLE: if (start_i) pend <= ch_mask_i;
        SELECT: begin
          ch <= ch_n;
          pend[ch_n] <= 1'b0;
          tap <= '0;
          cur_len <= '0;
          cur_start <= '0;
          cur_rot <= '0;
          best_len <= '0;
          best_start <= '0;
          best_rot <= '0;
        end
        LOAD: cnt <= '0;
        SETTLE: cnt <= settle_end ? '0 : cnt + CW'(1);
        DWELL: begin
          cnt <= cnt + CW'(1);
          dwell_ok <= cnt == '0 ? match : dwell_ok & match & (rot == dwell_rot);
          dwell_rot <= cnt == '0 ? rot : dwell_rot;
        end
        EVAL: begin
          if (extend) begin
            cur_len <= cur_len + 10'd1;
            if (cur_len == 10'd0) begin
              cur_start <= tap;
              cur_rot <= dwell_rot;
            end
          end else begin
            if (cur_len > best_len) begin
              best_len <= cur_len;
              best_start <= cur_start;
              best_rot <= cur_rot;
            end
            cur_len <= 10'(dwell_ok);
            cur_start <= tap;
            cur_rot <= dwell_rot;
          end
          if (!last) tap <= tap_nx;
        end
        CENTER: begin
          ch_ok_o[ch] <= lock;
          ch_tap_o[9*ch +: 9] <= lock ? centre[8:0] : 9'd0;
          ch_bitoff_o[2*ch +: 2] <= lock ? fin_rot : 2'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_turfio_cin_autoalign.sv
// tb_turfio_cin_autoalign: receiver model with per-tap eye tables, checked against a run-length reference.
module tb_turfio_cin_autoalign;
  localparam int NCH = 4, STEP = 8, TMAX = 511, SET = 8, DW = 16, MINE = 3;
  localparam int NPTS = TMAX / STEP + 1;
  logic rxclk_i = 0, rst_i = 0, start_i = 0;
  logic [NCH-1:0] ch_mask_i = '0;
  logic [4*NCH-1:0] data_i = '0;
  logic [NCH-1:0] delay_load_o, ch_ok_o;
  logic [1:0] delay_sel_o;
  logic [8:0] delay_cntvaluein_o;
  logic busy_o, done_o;
  logic [9*NCH-1:0] ch_tap_o;
  logic [2*NCH-1:0] ch_bitoff_o;
  logic [31:0] pat = 32'hA55A6996;
  int checks = 0, errors = 0;
  int pass_rot [NCH][512];
  int rx_tap [NCH];
  int loads [NCH];
  int exp_ok [NCH], exp_tap [NCH], exp_off [NCH];
  int load_seq [$];
  int first_val, done_cnt, cyc;

  turfio_cin_autoalign #(.NUM_CH(NCH), .TAP_STEP(STEP), .TAP_MAX(TMAX), .SETTLE_CYCLES(SET),
    .DWELL_CYCLES(DW), .MIN_EYE(MINE)) dut (
    .rxclk_i(rxclk_i), .rst_i(rst_i), .start_i(start_i), .ch_mask_i(ch_mask_i), .data_i(data_i),
    .delay_load_o(delay_load_o), .delay_sel_o(delay_sel_o), .delay_cntvaluein_o(delay_cntvaluein_o),
    .busy_o(busy_o), .done_o(done_o), .ch_ok_o(ch_ok_o), .ch_tap_o(ch_tap_o), .ch_bitoff_o(ch_bitoff_o));

  always #5 rxclk_i = ~rxclk_i;

  // Receivers: each channel emits the pattern bit stream offset by its eye rot, or noise outside the eye.
  initial begin
    logic [4*NCH-1:0] d;
    int r;
    for (int c = 0; c < NCH; c++) rx_tap[c] = 0;
    forever begin
      @(negedge rxclk_i);
      cyc++;
      if (rst_i) begin
        if (delay_load_o != '0) begin
          checks++;
          if ($countones(delay_load_o) != 1) begin
            errors++;
            $display("FAIL load_onehot: delay_load_o=%b required one-hot", delay_load_o);
          end
          for (int c = 0; c < NCH; c++) if (delay_load_o[c]) begin
            rx_tap[c] = int'(delay_cntvaluein_o);
            loads[c]++;
            if (load_seq.size() == 0) first_val = int'(delay_cntvaluein_o);
            load_seq.push_back(c);
          end
        end
        if (done_o) done_cnt++;
      end
      for (int c = 0; c < NCH; c++) begin
        r = pass_rot[c][rx_tap[c]];
        for (int i = 0; i < 4; i++) d[4*c+i] = r >= 0 ? pat[(4*cyc + i + r) % 32] : 1'($urandom);
      end
      data_i = d;
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge rxclk_i);
  endtask

  task automatic clear_eyes;
    for (int c = 0; c < NCH; c++) for (int t = 0; t < 512; t++) pass_rot[c][t] = -1;
  endtask

  task automatic set_eye(input int c, input int lo, input int hi, input int rot);
    for (int t = lo; t <= hi && t < 512; t++) pass_rot[c][t] = rot;
  endtask

  // Reference: widest run of equal-rot passing scan points, first one wins ties.
  task automatic model(input int c, output int ok, output int tap, output int off);
    int pts [$];
    int best_len, best_k, len;
    for (int t = 0; t <= TMAX; t += STEP) pts.push_back(pass_rot[c][t]);
    best_len = 0;
    best_k = 0;
    for (int k = 0; k < pts.size(); k++) begin
      if (pts[k] >= 0 && (k == 0 || pts[k-1] != pts[k])) begin
        len = 0;
        while (k + len < pts.size() && pts[k+len] == pts[k]) len++;
        if (len > best_len) begin
          best_len = len;
          best_k = k;
        end
      end
    end
    ok = best_len >= MINE;
    tap = ok ? best_k * STEP + ((best_len - 1) * STEP) / 2 : 0;
    off = ok ? pts[best_k] % 4 : 0;
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < NCH; c++) begin
      checks += 3;
      if (ch_ok_o[c] !== 1'(exp_ok[c])) begin
        errors++;
        $display("FAIL %s ch_ok[%0d]: got %b want %0d", tag, c, ch_ok_o[c], exp_ok[c]);
      end
      if (ch_tap_o[9*c +: 9] !== 9'(exp_tap[c])) begin
        errors++;
        $display("FAIL %s ch_tap[%0d]: got %0d want %0d", tag, c, ch_tap_o[9*c +: 9], exp_tap[c]);
      end
      if (ch_bitoff_o[2*c +: 2] !== 2'(exp_off[c])) begin
        errors++;
        $display("FAIL %s ch_bitoff[%0d]: got %0d want %0d", tag, c, ch_bitoff_o[2*c +: 2], exp_off[c]);
      end
    end
  endtask

  task automatic run(input string tag, input logic [NCH-1:0] mask, input bit spam);
    int n;
    bit order_ok;
    for (int c = 0; c < NCH; c++) loads[c] = 0;
    load_seq.delete();
    first_val = -1;
    done_cnt = 0;
    for (int c = 0; c < NCH; c++) if (mask[c]) model(c, exp_ok[c], exp_tap[c], exp_off[c]);
    @(negedge rxclk_i);
    ch_mask_i = mask;
    start_i = 1;
    @(negedge rxclk_i);
    start_i = 0;
    n = 0;
    while (done_cnt == 0 && n < 10000) begin
      start_i = spam && (n == 50 || n == 900);
      ch_mask_i = start_i ? '1 : mask;
      @(negedge rxclk_i);
      n++;
    end
    start_i = 0;
    clk_n(4);
    checks += 2;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d want 1 (waited %0d cycles)", tag, done_cnt, n);
    end
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after: got %b want 0", tag, busy_o);
    end
    check_outputs(tag);
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (loads[c] != (mask[c] ? NPTS + 1 : 0)) begin
        errors++;
        $display("FAIL %s load_count[%0d]: got %0d want %0d", tag, c, loads[c], mask[c] ? NPTS + 1 : 0);
      end
    end
    order_ok = 1;
    for (int i = 0; i < load_seq.size(); i++)
      if (!mask[load_seq[i]] || (i > 0 && load_seq[i] < load_seq[i-1])) order_ok = 0;
    checks++;
    if (!order_ok) begin
      errors++;
      $display("FAIL %s load_order: strobes out of order or to unmasked channel, mask %b", tag, mask);
    end
    if (mask != '0) begin
      checks++;
      if (first_val != 0) begin
        errors++;
        $display("FAIL %s first_tap: got %0d want 0", tag, first_val);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    checks += 7;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", tag, busy_o); end
    if (done_o !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", tag, done_o); end
    if (delay_load_o !== '0) begin errors++; $display("FAIL %s load: got %b want 0", tag, delay_load_o); end
    if (delay_cntvaluein_o !== '0) begin errors++; $display("FAIL %s cntvalue: got %0d want 0", tag, delay_cntvaluein_o); end
    if (ch_ok_o !== '0) begin errors++; $display("FAIL %s ch_ok: got %b want 0", tag, ch_ok_o); end
    if (ch_tap_o !== '0) begin errors++; $display("FAIL %s ch_tap: got %h want 0", tag, ch_tap_o); end
    if (ch_bitoff_o !== '0) begin errors++; $display("FAIL %s ch_bitoff: got %h want 0", tag, ch_bitoff_o); end
  endtask

  task automatic test_reset;
    clk_n(3);
    check_zero("reset");
    checks++;
    if (delay_sel_o !== 2'b00) begin errors++; $display("FAIL reset sel: got %b want 00", delay_sel_o); end
    rst_i = 1;
    for (int c = 0; c < NCH; c++) begin exp_ok[c] = 0; exp_tap[c] = 0; exp_off[c] = 0; end
  endtask

  task automatic test_directed;
    clear_eyes; set_eye(0, 96, 192, 2);
    run("single_eye", 4'b0001, 0);
    clear_eyes; set_eye(0, 40, 48, 1);
    run("small_eye", 4'b0001, 0);
    clear_eyes; set_eye(0, 16, 48, 1); set_eye(0, 200, 264, 0);
    run("two_eyes", 4'b0001, 0);
    clear_eyes; set_eye(0, 16, 48, 3); set_eye(0, 200, 232, 2);
    run("equal_eyes", 4'b0001, 0);
    clear_eyes; set_eye(0, 96, 143, 1); set_eye(0, 144, 192, 3);
    run("rot_split", 4'b0001, 0);
  endtask

  task automatic random_eyes(input bit force_lock);
    int lo;
    clear_eyes;
    for (int c = 0; c < NCH; c++) begin
      if (force_lock) begin
        lo = $urandom_range(0, 400);
        set_eye(c, lo, lo + $urandom_range(3 * STEP, 100), $urandom_range(0, 3));
      end
      repeat ($urandom_range(0, 2)) begin
        lo = $urandom_range(0, 480);
        set_eye(c, lo, lo + $urandom_range(0, 160), $urandom_range(0, 3));
      end
    end
  endtask

  task automatic test_mask;
    random_eyes(1);
    run("mask_all", 4'b1111, 0);
    random_eyes(1);
    run("mask_1010", 4'b1010, 0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 3; it++) begin
      random_eyes($urandom_range(0, 1));
      run($sformatf("random%0d", it), NCH'($urandom_range(1, 15)), 0);
    end
  endtask

  task automatic test_empty_mask;
    @(negedge rxclk_i);
    ch_mask_i = '0;
    start_i = 1;
    @(negedge rxclk_i);
    start_i = 0;
    checks += 2;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL empty_select: busy=%b done=%b want busy=1 done=0", busy_o, done_o);
    end
    @(negedge rxclk_i);
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL empty_done: busy=%b done=%b want busy=0 done=1", busy_o, done_o);
    end
    @(negedge rxclk_i);
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL empty_done_width: done=%b want 0", done_o); end
    check_outputs("empty_mask");
  endtask

  task automatic test_reset_midrun;
    int n;
    clear_eyes; set_eye(0, 96, 192, 2); set_eye(1, 40, 200, 1);
    for (int c = 0; c < NCH; c++) loads[c] = 0;
    load_seq.delete();
    @(negedge rxclk_i);
    ch_mask_i = 4'b0011;
    start_i = 1;
    @(negedge rxclk_i);
    start_i = 0;
    n = 0;
    while (loads[1] == 0 && n < 10000) begin @(negedge rxclk_i); n++; end
    checks++;
    if (loads[1] == 0) begin errors++; $display("FAIL midrun_wait: no strobe to channel 1 after %0d cycles", n); end
    clk_n(12);
    checks++;
    if (ch_ok_o[0] !== 1'b1) begin errors++; $display("FAIL midrun_ch0_ok: got %b want 1", ch_ok_o[0]); end
    #2 rst_i = 0;
    #1 check_zero("async_reset");
    @(negedge rxclk_i);
    rst_i = 1;
    for (int c = 0; c < NCH; c++) begin exp_ok[c] = 0; exp_tap[c] = 0; exp_off[c] = 0; end
    run("after_reset", 4'b0010, 1);
  endtask

  initial begin
    clear_eyes;
    test_reset;
    test_directed;
    test_mask;
    test_empty_mask;
    test_random;
    test_reset_midrun;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
